// File: rtl/sequence_playback_ctrl.sv
// rtl/sequence_playback_ctrl.sv - Pattern-table playback controller on a valid/ready stream.
// Plays table[0..len] for a set number of passes (0 = endless) with pause and abort.
module sequence_playback_ctrl #(
  parameter int DW    = 3,
  parameter int DEPTH = 8,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [DW-1:0]    cfg_data,
  input  logic [2:0]       cfg_len,
  input  logic [RPT_W-1:0] cfg_rpt,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dout_ready,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state, state_d;
  logic [DW-1:0]    tbl [DEPTH];
  logic [2:0]       idx, idx_d, idx_inc, len_q, len_d;
  logic [RPT_W-1:0] pass_cnt, pass_d, rpt_q, rpt_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             cfg_err_q;
  logic             xfer, tbl_wr, last_beat, final_pass;

  function automatic logic [DW-1:0] default_entry(input int i);
    case (i)
      0:       default_entry = DW'(1);
      1:       default_entry = DW'(6);
      2:       default_entry = DW'(5);
      3:       default_entry = DW'(7);
      4:       default_entry = DW'(3);
      5:       default_entry = DW'(2);
      6:       default_entry = DW'(4);
      default: default_entry = DW'(0);
    endcase
  endfunction

  assign xfer       = (state == RUN) && dout_ready;
  assign tbl_wr     = cfg_we && (state == IDLE || state == DONE);
  assign last_beat  = (idx == len_q);
  assign final_pass = (rpt_q != '0) && (pass_cnt == rpt_q - RPT_W'(1));
  assign idx_inc    = idx + 3'd1;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    pass_d  = pass_cnt;
    len_d   = len_q;
    rpt_d   = rpt_q;
    dout_d  = dout_q;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          len_d   = cfg_len;
          rpt_d   = cfg_rpt;
          idx_d   = '0;
          pass_d  = '0;
          // A same-cycle write to entry 0 must be seen by the first beat.
          dout_d  = (tbl_wr && cfg_addr == 3'd0) ? cfg_data : tbl[0];
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (xfer) begin
          if (!last_beat) begin
            idx_d  = idx_inc;
            dout_d = tbl[idx_inc];
            if (pause) state_d = PAUSE;
          end else if (final_pass) begin
            state_d = DONE;
          end else begin
            idx_d  = '0;
            dout_d = tbl[0];
            if (rpt_q != '0) pass_d = pass_cnt + RPT_W'(1);
            if (pause) state_d = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      pass_cnt  <= '0;
      len_q     <= '0;
      rpt_q     <= '0;
      dout_q    <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= default_entry(i);
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      pass_cnt  <= pass_d;
      len_q     <= len_d;
      rpt_q     <= rpt_d;
      dout_q    <= dout_d;
      cfg_err_q <= cfg_we && !tbl_wr;
      if (tbl_wr) tbl[cfg_addr] <= cfg_data;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state == RUN);
  assign busy       = (state == RUN) || (state == PAUSE);
  assign done       = (state == DONE);
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_sequence_playback_ctrl.sv
// tb/tb_sequence_playback_ctrl.sv - Directed self-checking bench for sequence_playback_ctrl.
module tb_sequence_playback_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [2:0] cfg_data = '0;
  logic [2:0] cfg_len = '0;
  logic [3:0] cfg_rpt = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       dout_ready = 1'b0;
  logic [2:0] dout;
  logic       dout_valid, busy, done, cfg_err;

  int tests = 0;
  int fails = 0;

  logic [2:0] dflt   [8] = '{3'd1, 3'd6, 3'd5, 3'd7, 3'd3, 3'd2, 3'd4, 3'd0};
  logic [2:0] mod3   [8] = '{3'd3, 3'd0, 3'd5, 3'd3, 3'd0, 3'd5, 3'd0, 3'd0};
  logic [2:0] modall [8] = '{3'd3, 3'd0, 3'd5, 3'd7, 3'd3, 3'd2, 3'd4, 3'd0};
  logic [2:0] resume [12] = '{3'd7, 3'd3, 3'd2, 3'd4, 3'd1, 3'd6, 3'd5, 3'd7, 3'd3, 3'd2, 3'd4, 3'd1};
  logic [2:0] ones   [8] = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [2:0] got [$];
  logic [2:0] prev;
  logic       held, seen;

  sequence_playback_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .cfg_rpt(cfg_rpt), .start(start), .stop(stop), .pause(pause),
    .dout_ready(dout_ready), .dout(dout), .dout_valid(dout_valid), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [2:0] len, input logic [3:0] rpt);
    cfg_len = len;
    cfg_rpt = rpt;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic play(input string tag, input int n, input logic [2:0] exp [8]);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_v%0d", tag, i), dout_valid, 1);
      chk($sformatf("%s_d%0d", tag, i), dout, exp[i]);
      step();
    end
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    step();
    chk({tag, "_done_end"}, done, 0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [2:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    step();
    rst = 1'b0;
    step();

    // Single pass of the default table
    dout_ready = 1'b1;
    kick(3'd6, 4'd1);
    play("t1", 7, dflt);
    expect_done("t1");

    // Backpressure: ready 1,0,0 repeating
    kick(3'd6, 4'd1);
    got.delete();
    seen = 1'b0;
    held = 1'b0;
    prev = '0;
    for (int c = 0; c < 60 && !seen; c++) begin
      dout_ready = (c % 3 == 0);
      if (held) chk($sformatf("t2_hold%0d", c), dout, prev);
      if (dout_valid && dout_ready) got.push_back(dout);
      held = dout_valid && !dout_ready;
      prev = dout;
      step();
      if (done) seen = 1'b1;
    end
    dout_ready = 1'b1;
    chk("t2_done_seen", seen, 1);
    chk("t2_count", got.size(), 7);
    for (int i = 0; i < 7 && i < got.size(); i++) chk($sformatf("t2_d%0d", i), got[i], dflt[i]);
    step();

    // Modified entries 0..2, two passes; then full-length check of untouched entries
    wr(3'd0, 3'd3);
    wr(3'd1, 3'd0);
    wr(3'd2, 3'd5);
    kick(3'd2, 4'd2);
    play("t3", 6, mod3);
    expect_done("t3");
    kick(3'd7, 4'd1);
    play("t3b", 8, modall);
    expect_done("t3b");

    // Restore entries; entry 0 written in the same cycle as start
    wr(3'd1, 3'd6);
    wr(3'd2, 3'd5);
    cfg_we = 1'b1;
    cfg_addr = 3'd0;
    cfg_data = 3'd1;
    kick(3'd6, 4'd0);
    cfg_we = 1'b0;
    chk("t4_first", dout, 1);
    step();
    chk("t4_second", dout, 6);
    step();
    chk("t4_third", dout, 5);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t4_pv%0d", i), dout_valid, 0);
      chk($sformatf("t4_pd%0d", i), dout, 7);
      chk($sformatf("t4_pb%0d", i), busy, 1);
    end
    pause = 1'b0;
    step();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t4_rv%0d", i), dout_valid, 1);
      chk($sformatf("t4_rd%0d", i), dout, resume[i]);
      chk($sformatf("t4_nd%0d", i), done, 0);
      step();
    end

    // Rejected write while busy, then abort
    wr(3'd1, 3'd2);
    chk("t5_err", cfg_err, 1);
    step();
    chk("t5_err_end", cfg_err, 0);
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      if (dout_valid && dout == 3'd1) seen = 1'b1;
      step();
    end
    chk("t5_found1", seen, 1);
    chk("t5_entry1", dout, 6);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t5_stop_valid", dout_valid, 0);
    chk("t5_stop_busy", busy, 0);
    chk("t5_stop_done", done, 0);
    step();
    chk("t5_stop_done2", done, 0);

    // Single-entry passes
    kick(3'd0, 4'd3);
    play("t6", 3, ones);
    expect_done("t6");

    // Async reset mid-run discards table writes
    wr(3'd4, 3'd6);
    kick(3'd6, 4'd0);
    step();
    step();
    step();
    chk("t7_pre", dout, 7);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_dout", dout, 0);
    chk("t7_rst_valid", dout_valid, 0);
    chk("t7_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    step();
    kick(3'd6, 4'd1);
    play("t7", 7, dflt);
    expect_done("t7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
